// File: rtl/mem_arbiter.sv
// Round-robin arbiter that funnels an instruction-fetch port and a data port onto one
// request/wait memory bus, one transaction at a time, with a WAIT-phase timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic        mem_wait,
    input  logic [31:0] mem_read_data
);

    localparam int   CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_r;
    logic             owner_r;
    logic             last_r;
    logic             grant_s;
    logic             done_s;
    logic             timeout_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [31:0]      resp_data_s;

    // Round-robin pick among live requests; a tie goes to the port not granted last.
    always_comb begin
        grant_s = PORT_I;
        if (i_req && d_req) begin
            grant_s = (last_r == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req) begin
            grant_s = PORT_D;
        end else begin
            grant_s = PORT_I;
        end
    end

    // WAIT exit conditions; the first WAIT cycle (count 0) never completes on mem_wait.
    always_comb begin
        done_s      = (wait_cnt_r != {CNT_W{1'b0}}) && !mem_wait;
        timeout_s   = !done_s && (wait_cnt_r == CNT_W'(TIMEOUT));
        resp_data_s = 32'h0000_0000;
        if (done_s && !mem_rw) begin
            resp_data_s = mem_read_data;
        end else begin
            resp_data_s = 32'h0000_0000;
        end
    end

    // Transaction FSM; every bus and response output is a register written here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            owner_r        <= PORT_I;
            last_r         <= PORT_I;
            wait_cnt_r     <= {CNT_W{1'b0}};
            i_ack          <= 1'b0;
            d_ack          <= 1'b0;
            err            <= 1'b0;
            i_rdata        <= 32'h0000_0000;
            d_rdata        <= 32'h0000_0000;
            mem_enable     <= 1'b0;
            mem_rw         <= 1'b0;
            mem_address    <= 32'h0000_0000;
            mem_write_data <= 32'h0000_0000;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_r        <= grant_s;
                        last_r         <= grant_s;
                        mem_enable     <= 1'b1;
                        mem_rw         <= (grant_s == PORT_D) ? d_rw : 1'b0;
                        mem_address    <= (grant_s == PORT_D) ? d_addr : i_addr;
                        mem_write_data <= (grant_s == PORT_D) ? d_wdata : 32'h0000_0000;
                        wait_cnt_r     <= {CNT_W{1'b0}};
                        state_r        <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (done_s || timeout_s) begin
                        mem_enable <= 1'b0;
                        err        <= timeout_s;
                        if (owner_r == PORT_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= resp_data_s;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= resp_data_s;
                        end
                        state_r <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                        state_r    <= WAIT;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, contention/timeout/reset sequences and a
// randomized run scored against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int TO_LONG  = 64;
    localparam int TO_SHORT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, i_req, d_req, d_rw, mem_wait, mem_wait8;
    logic [31:0] i_addr, d_addr, d_wdata, mem_read_data, mem_read_data8;
    logic        i_ack, d_ack, err, mem_enable, mem_rw;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_write_data;
    logic        i_ack8, d_ack8, err8, mem_enable8, mem_rw8;
    logic [31:0] i_rdata8, d_rdata8, mem_address8, mem_write_data8;

    mem_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_wait(mem_wait), .mem_read_data(mem_read_data)
    );

    // Short-timeout instance with its own memory-side inputs.
    mem_arbiter #(.TIMEOUT(TO_SHORT)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack8), .i_rdata(i_rdata8),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack8), .d_rdata(d_rdata8), .err(err8),
        .mem_enable(mem_enable8), .mem_rw(mem_rw8), .mem_address(mem_address8),
        .mem_write_data(mem_write_data8), .mem_wait(mem_wait8), .mem_read_data(mem_read_data8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- memory model for u_dut ----------------
    logic [31:0] mem_q [int];
    int          busy_override = 0;
    int          busy_left;
    logic        prev_en;

    function automatic int busy_of(input logic [31:0] a);
        return (busy_override >= 0) ? busy_override : int'((a >> 2) & 32'd7);
    endfunction

    function automatic logic [31:0] default_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // mem_wait is high for the first busy_of(addr) WAIT cycles of each access.
    initial begin
        busy_left = 0; prev_en = 1'b0; mem_wait = 1'b0; mem_read_data = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (mem_enable && !prev_en) begin
                busy_left = busy_of(mem_address);
                mem_wait  = (busy_left > 0);
                if (mem_rw) mem_q[int'(mem_address)] = mem_write_data;
            end else if (mem_enable) begin
                mem_wait = (busy_left > 0);
                if (busy_left > 0) busy_left--;
            end else begin
                mem_wait = 1'b0;
            end
            prev_en = mem_enable;
            mem_read_data = mem_q.exists(int'(mem_address)) ? mem_q[int'(mem_address)]
                                                            : default_word(mem_address);
        end
    end

    // ---------------- directed vectors ----------------
    // exp_cycle: ack is seen in this cycle counting the ISSUE cycle as 1.
    typedef struct {
        bit          port_d;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          busy;
        logic [31:0] exp_rdata;
        int          exp_cycle;
    } vec_t;

    vec_t vecs[7];

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_rw = 1'b0; mem_wait8 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        bit got, bus_ok;
        logic ack_v;
        logic [31:0] rdata_v;
        @(negedge clk);
        busy_override = v.busy;
        if (v.port_d) begin
            d_req = 1'b1; d_rw = v.rw; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        @(posedge clk);
        n = 0; got = 1'b0; bus_ok = 1'b1;
        while (!got && n < 200) begin
            #1; n++;
            if (mem_enable && (mem_rw !== v.rw || mem_address !== v.addr ||
                               (v.rw && mem_write_data !== v.wdata))) bus_ok = 1'b0;
            if (n < v.exp_cycle && mem_enable !== 1'b1) bus_ok = 1'b0;
            ack_v = v.port_d ? d_ack : i_ack;
            if (ack_v === 1'b1) got = 1'b1;
            else @(posedge clk);
        end
        rdata_v = v.port_d ? d_rdata : i_rdata;
        check32($sformatf("v%0d ack cycle", idx), 32'(n), 32'(v.exp_cycle));
        check32($sformatf("v%0d rdata", idx), rdata_v, v.exp_rdata);
        check32($sformatf("v%0d err", idx), {31'b0, err}, 32'd0);
        check32($sformatf("v%0d other ack", idx), {31'b0, v.port_d ? i_ack : d_ack}, 32'd0);
        check32($sformatf("v%0d mem_enable in RESP", idx), {31'b0, mem_enable}, 32'd0);
        check32($sformatf("v%0d bus held", idx), {31'b0, bus_ok}, 32'd1);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        check32($sformatf("v%0d ack pulse", idx), {30'b0, i_ack, d_ack}, 32'd0);
        check32($sformatf("v%0d mem_enable gap", idx), {31'b0, mem_enable}, 32'd0);
    endtask

    // ---------------- randomized phase state ----------------
    bit          pend_i, pend_d, drop_i, drop_d, act, own_d, last_d, exp_rw, exp_en, resp_now;
    int          cyc, g, dcy, resp_at, next_free, n, n_acks;
    logic [31:0] exp_addr, exp_rdata, exp_i_rdata, exp_d_rdata, code;
    logic [31:0] ref_q [int];
    bit          both_ack;

    initial begin
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_rw = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_wait8 = 1'b0; mem_read_data8 = 32'h600D_F00D;
        mem_q[32'h100] = 32'hDEAD_BEEF;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,          16, 32'hDEAD_BEEF, 19};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678,  3, 32'h0,           6};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,           0, 32'h1234_5678,  4};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,           1, 32'h1234_5678,  4};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,           2, 32'hA5A5_0044,  5};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_BABE,   0, 32'h0,           4};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,           5, 32'hCAFE_BABE,  8};

        repeat (2) @(posedge clk); #1;
        check32("reset acks/err", {29'b0, i_ack, d_ack, err}, 32'd0);
        check32("reset mem_enable/rw", {30'b0, mem_enable, mem_rw}, 32'd0);
        check32("reset i_rdata", i_rdata, 32'd0);
        check32("reset d_rdata", d_rdata, 32'd0);
        check32("reset mem_address", mem_address, 32'd0);
        check32("reset mem_write_data", mem_write_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Contention: both ports held high from reset, order must be D, I, D, I.
        apply_reset();
        busy_override = 0;
        @(negedge clk);
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h300; i_req = 1'b1; i_addr = 32'h304;
        code = 32'd0; n_acks = 0; both_ack = 1'b0;
        for (int c = 0; c < 60 && n_acks < 4; c++) begin
            @(posedge clk); #1;
            if (i_ack && d_ack) both_ack = 1'b1;
            if (d_ack) begin code = (code << 2) | 32'd1; n_acks++; end
            else if (i_ack) begin code = (code << 2) | 32'd2; n_acks++; end
        end
        check32("contention ack count", 32'(n_acks), 32'd4);
        check32("contention order", code, 32'h0000_0066);
        check32("contention single owner", {31'b0, both_ack}, 32'd0);

        // Timeout on the short instance, then a normal fetch on it.
        apply_reset();
        busy_override = 0;
        mem_wait8 = 1'b1;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h500;
        @(posedge clk);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            #1; n++;
            if (i_ack8 === 1'b1) break;
            @(posedge clk);
        end
        check32("timeout ack cycle", 32'(n), 32'(TO_SHORT + 3));
        check32("timeout err", {31'b0, err8}, 32'd1);
        check32("timeout rdata", i_rdata8, 32'd0);
        check32("timeout mem_enable", {31'b0, mem_enable8}, 32'd0);
        @(negedge clk);
        i_req = 1'b0; mem_wait8 = 1'b0;
        @(posedge clk); #1;
        check32("timeout err pulse", {30'b0, err8, i_ack8}, 32'd0);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h504;
        @(posedge clk);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            #1; n++;
            if (i_ack8 === 1'b1) break;
            @(posedge clk);
        end
        check32("post-timeout ack cycle", 32'(n), 32'd4);
        check32("post-timeout err", {31'b0, err8}, 32'd0);
        check32("post-timeout rdata", i_rdata8, 32'h600D_F00D);
        @(negedge clk);
        i_req = 1'b0;

        // Reset during WAIT abandons the fetch.
        apply_reset();
        busy_override = 10;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h100;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; i_req = 1'b0;
        @(posedge clk); #1;
        check32("mid-reset acks/err", {29'b0, i_ack, d_ack, err}, 32'd0);
        check32("mid-reset mem_enable/rw", {30'b0, mem_enable, mem_rw}, 32'd0);
        check32("mid-reset mem_address", mem_address, 32'd0);
        check32("mid-reset rdata", i_rdata | d_rdata | mem_write_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_acks = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (i_ack || d_ack) n_acks++;
        end
        check32("mid-reset no ack", 32'(n_acks), 32'd0);
        run_vec('{1'b0, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 4}, 7);

        // Randomized traffic scored against a transaction-level model.
        apply_reset();
        busy_override = -1;
        pend_i = 0; pend_d = 0; drop_i = 0; drop_d = 0; act = 0; last_d = 0;
        exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
        cyc = 0; next_free = 0; g = 0; dcy = 0; resp_at = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (drop_i) begin i_req = 1'b0; pend_i = 0; drop_i = 0; end
            else if (!pend_i && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; pend_i = 1; i_addr = 32'h200 + 32'(4 * $urandom_range(0, 7));
            end
            if (drop_d) begin d_req = 1'b0; pend_d = 0; drop_d = 0; end
            else if (!pend_d && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; pend_d = 1; d_rw = 1'($urandom_range(0, 1));
                d_addr = 32'h200 + 32'(4 * $urandom_range(0, 7)); d_wdata = $urandom;
            end
            @(posedge clk);
            cyc++;
            if (!act && cyc >= next_free && (pend_i || pend_d)) begin
                own_d    = (pend_i && pend_d) ? !last_d : pend_d;
                last_d   = own_d;
                exp_addr = own_d ? d_addr : i_addr;
                exp_rw   = own_d ? d_rw : 1'b0;
                dcy      = busy_of(exp_addr) + 1;
                if (dcy < 2) dcy = 2;
                if (dcy > TO_LONG + 1) dcy = TO_LONG + 1;
                g = cyc; resp_at = g + dcy + 1; act = 1;
                if (exp_rw) begin
                    ref_q[int'(exp_addr)] = d_wdata;
                    exp_rdata = 32'h0;
                end else begin
                    exp_rdata = ref_q.exists(int'(exp_addr)) ? ref_q[int'(exp_addr)]
                                                            : default_word(exp_addr);
                end
            end
            #1;
            exp_en   = act && cyc >= g && cyc <= g + dcy;
            resp_now = act && cyc == resp_at;
            check32("rand mem_enable", {31'b0, mem_enable}, {31'b0, exp_en});
            if (exp_en) begin
                check32("rand mem_address", mem_address, exp_addr);
                check32("rand mem_rw", {31'b0, mem_rw}, {31'b0, exp_rw});
            end
            if (resp_now) begin
                if (own_d) begin exp_d_rdata = exp_rdata; drop_d = 1; end
                else begin exp_i_rdata = exp_rdata; drop_i = 1; end
                act = 0; next_free = cyc + 2;
            end
            check32("rand acks", {30'b0, i_ack, d_ack},
                    {30'b0, resp_now && !own_d, resp_now && own_d});
            check32("rand err", {31'b0, err}, 32'd0);
            check32("rand i_rdata", i_rdata, exp_i_rdata);
            check32("rand d_rdata", d_rdata, exp_d_rdata);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles spent in WAIT before a transaction is aborted.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_req  input  1  instruction-fetch read request; held high until i_ack.
REQ-005 i_addr  input  32  fetch byte address; stable while i_req is high.
REQ-006 i_ack  output  1  one-cycle pulse; fetch transaction complete.
REQ-007 i_rdata  output  32  fetch read data; valid in the i_ack cycle.
REQ-008 d_req  input  1  data-port request; held high until d_ack.
REQ-009 d_rw  input  1  0 = read, 1 = write; stable while d_req is high.
REQ-010 d_addr  input  32  data byte address; stable while d_req is high.
REQ-011 d_wdata  input  32  write data; stable while d_req is high.
REQ-012 d_ack  output  1  one-cycle pulse; data transaction complete.
REQ-013 d_rdata  output  32  data read data; valid in the d_ack cycle (0 for writes).
REQ-014 err  output  1  one-cycle pulse coincident with an ack; the transaction timed out.
REQ-015 mem_enable  output  1  memory select.
REQ-016 mem_rw  output  1  memory direction, 0 = read, 1 = write.
REQ-017 mem_address  output  32  memory byte address.
REQ-018 mem_write_data  output  32  memory write data.
REQ-019 mem_wait  input  1  memory busy; high while an access is in progress.
REQ-020 mem_read_data  input  32  memory read data.

Function
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: on any request, latch the owner, rw, address and wdata, then go to ISSUE; with no request, stay in IDLE.
REQ-023 Fetch transactions SHALL always latch rw = 0; i_addr and d_addr are passed to memory unmodified (byte addresses).
REQ-024 Arbitration SHALL be round-robin: if i_req and d_req are both high in IDLE, grant the port not granted last.
REQ-025 The last-grant pointer SHALL reset to FETCH, so the first tie goes to the data port.
REQ-026 A single request SHALL be granted regardless of the pointer; the pointer updates on every grant.
REQ-027 ISSUE SHALL last exactly one cycle, with mem_enable = 1 and the latched rw/address/wdata driven; next state is WAIT.
REQ-028 WAIT: mem_enable, mem_rw, mem_address and mem_write_data SHALL stay constant.
REQ-029 WAIT: mem_wait SHALL be ignored in the first WAIT cycle.
REQ-030 WAIT: from the second cycle on, mem_wait = 0 completes the transaction; capture mem_read_data (reads) and go to RESP.
REQ-031 A timeout counter SHALL increment each WAIT cycle; on reaching TIMEOUT without completion, the block sets an error flag, captures rdata = 0 and goes to RESP.
REQ-032 RESP SHALL last one cycle: mem_enable = 0, and only the owner's ack pulses with its rdata; err equals the error flag; next state is IDLE.
REQ-033 Requests are not sampled in RESP, so the earliest next grant is the cycle after RESP.
REQ-034 Minimum transaction latency, from the request-sampled edge to the ack cycle, SHALL be 4 cycles (IDLE, ISSUE, WAIT x1 ignored + 1 done, RESP).
REQ-035 A requester dropping req mid-transaction SHALL NOT abort it; its ack still pulses.
REQ-036 The non-owner's ack SHALL stay 0; its rdata holds its previous value.
REQ-037 mem_enable SHALL be 0 in IDLE and RESP, and never high for two back-to-back transactions without an intervening low cycle.

Reset
REQ-038 While rst_n = 0 at an edge: state = IDLE, last-grant = FETCH, counter = 0; i_ack, d_ack, err, mem_enable, mem_rw = 0; i_rdata, d_rdata, mem_address, mem_write_data = 0.
REQ-039 Reset asserted mid-transaction SHALL abandon it with no ack and mem_enable = 0 in the following cycle.

Verification
REQ-040 Fetch only: i_req, i_addr = 0x100, memory model with 16 busy cycles returning 0xDEADBEEF -> one i_ack pulse with i_rdata = 0xDEADBEEF; mem_rw = 0 throughout; err = 0.
REQ-041 Write then read: d_rw = 1, addr 0x40, wdata 0x12345678, then d_rw = 0 on addr 0x40 -> two d_acks; read returns 0x12345678; mem_enable low for at least one cycle between them.
REQ-042 Contention: i_req and d_req held high simultaneously from reset -> grants alternate D, I, D, I; no ack to a non-owner.
REQ-043 Timeout: TIMEOUT = 8, mem_wait stuck at 1 -> ack with err = 1 and rdata = 0 in the 10th cycle after ISSUE; the next request is serviced normally.
REQ-044 Reset mid-WAIT: assert rst_n = 0 for one cycle during WAIT -> no ack; all outputs equal reset values; a fresh fetch then completes normally.
REQ-045 Zero-wait memory (mem_wait always 0): fetch acks exactly 4 cycles after the request is sampled.
